imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning instruction-memory word-address width (4 KB at the default).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles fetch may be denied while the loader holds the lock.
REQ-003 SHALL have port clk  in  1  system clock; the block uses one clock, and all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have the following fetch-side ports:
- f_req  in  1  fetch request
- f_addr  in  32  byte address
- f_gnt  out  1  request accepted this cycle
- f_rvalid  out  1  read data valid
- f_rdata  out  32  instruction word
- f_err  out  1  misaligned or out-of-range fetch
REQ-006 SHALL have the following loader-side ports:
- l_req  in  1  loader request
- l_we  in  1  write (1) or read (0)
- l_lock  in  1  hold ownership across a burst
- l_addr  in  32  byte address
- l_wdata  in  32  write data
- l_gnt  out  1  request accepted
- l_rvalid  out  1  read data valid
- l_rdata  out  32  read data
REQ-007 SHALL have the following memory-side ports:
- mem_en  out  1  access enable
- mem_we  out  1  write enable
- mem_addr  out  AW  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  synchronous read data, 1-cycle latency

Function
REQ-008 SHALL grant at most one requester per cycle; the grant is combinational from the current state and requests; mem_en equals f_gnt OR l_gnt.
REQ-009 SHALL drive mem_addr from the granted requester's addr[AW+1:2], and mem_wdata/mem_we from the loader only when l_gnt is high (mem_we=0 otherwise).
REQ-010 SHALL implement the FSM states IDLE, FETCH, LOAD, where the state records the owner of the last grant.
REQ-011 SHALL resolve simultaneous requests round-robin in IDLE and FETCH: the requester not granted last wins; after reset, the loader wins the first tie.
REQ-012 SHALL handle the LOAD state with l_lock=1 as follows: the loader keeps priority and fetch is denied; a starve counter increments on each cycle that f_req is denied; when the counter reaches STARVE_MAX, fetch wins the next cycle and the counter clears.
REQ-013 SHALL clear the starve counter whenever fetch is granted or f_req=0.
REQ-014 SHALL update the state on each grant: to FETCH on f_gnt, to LOAD on l_gnt; with no grant, LOAD with l_lock=0 and FETCH both return to IDLE.
REQ-015 SHALL assert f_rvalid exactly one cycle after f_gnt, with f_rdata=mem_rdata; likewise l_rvalid one cycle after a loader read grant (l_we=0); a loader write produces no rvalid.
REQ-016 SHALL use a registered response tag (none/fetch/loader) to steer mem_rdata, so that back-to-back grants of alternating owners each return correctly.
REQ-017 SHALL treat a fetch with f_addr[1:0]!=0, or with f_addr[31:AW+2]!=0, as erroneous: it is never granted to memory, and f_err pulses one cycle later with f_rvalid=1 and f_rdata=0xC8000000 (NOP). An erroneous fetch counts as a fetch grant for round-robin purposes.
REQ-018 SHALL silently drop a loader address with nonzero low bits by using the word address only; no loader error is reported.
REQ-019 SHALL hold f_rdata/l_rdata at their last value when the corresponding rvalid is 0.

Reset
REQ-020 SHALL apply the following values while rst=1 at a clock edge:
- state=IDLE, round-robin pointer=loader-first, starve counter=0, response tag=none
- f_rvalid=0, l_rvalid=0, f_err=0, f_rdata=0, l_rdata=0
REQ-021 SHALL force all grants and mem_en/mem_we to 0 while rst=1, and SHALL discard an access granted in the cycle before reset (no rvalid after reset).

Structure
REQ-022 SHALL place the state enum, the response-tag enum and the NOP constant 0xC8000000 in the shared package scc_pkg.
REQ-023 SHALL use one sub-module, rr_arb2 (a two-requester round-robin arbiter with pointer register); the starve logic and FSM remain in imem_arbiter.

Verification
REQ-024 SHALL cover a single fetch: f_addr=0x10 -> mem_addr=4 in the same cycle, f_rvalid=1 next cycle with f_rdata=mem_rdata.
REQ-025 SHALL cover a tie after reset: f_req=l_req=1 for 2 cycles -> l_gnt on cycle 1, f_gnt on cycle 2, and rvalids in order loader then fetch.
REQ-026 SHALL cover starvation: l_lock=1 with l_req=f_req=1 continuously and STARVE_MAX=4 -> 4 loader grants, then 1 fetch grant, then the loader again.
REQ-027 SHALL cover misalignment: f_addr=0x6 -> no mem_en, and next cycle f_err=1, f_rvalid=1, f_rdata=0xC8000000.
REQ-028 SHALL cover a loader write followed by a fetch of the same word: l_we=1, l_addr=0x20, l_wdata=0xDEADBEEF -> mem_we=1, mem_addr=8, no l_rvalid; a subsequent fetch of 0x20 issues mem_addr=8.
REQ-029 SHALL cover reset mid-access: f_gnt in cycle N and rst=1 in cycle N+1 -> f_rvalid=0 in N+1, with all outputs at their reset values.

Source files
------------

// File: rtl/scc_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package scc_pkg;

    // FSM state: records who owned the most recent grant.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2
    } arb_state_e;

    // Owner of the read response due back from memory next cycle.
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LOAD  = 2'd2
    } rsp_tag_e;

    // Instruction returned for a rejected fetch.
    localparam logic [31:0] NOP_INSN = 32'hC800_0000;

    // Bit positions of the two requesters in request/grant vectors.
    localparam int REQ_F = 0;
    localparam int REQ_L = 1;

    // A fetch must be word aligned and fall inside the 2^(aw+2)-byte memory.
    function automatic logic fetch_addr_bad(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer is advanced from the grant
// the parent actually issued, so overrides made outside this block still
// count towards fairness.
module rr_arb2
    import scc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [1:0] won_i,
    output logic [1:0] gnt_o
);

    // 1: the loader wins the next tie; 0: fetch wins the next tie.
    logic pri_l_q;
    logic pri_l_d;

    // A lone requester wins outright; a tie goes to whoever was not served last.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o        = 2'b00;
            gnt_o[REQ_L] = pri_l_q;
            gnt_o[REQ_F] = ~pri_l_q;
        end
    end

    // Hand priority to the requester that was not granted this cycle.
    always_comb begin
        pri_l_d = pri_l_q;
        if (won_i[REQ_F]) begin
            pri_l_d = 1'b1;
        end else if (won_i[REQ_L]) begin
            pri_l_d = 1'b0;
        end
    end

    // Pointer register; after reset the loader wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_l_q <= 1'b1;
        end else begin
            pri_l_q <= pri_l_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port synchronous SRAM between
// the instruction fetch unit and a loader. The loader can lock the memory for
// bursts, but fetch is never denied for more than STARVE_MAX cycles in a row.
module imem_arbiter
    import scc_pkg::*;
#(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch side
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    // loader side
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    rsp_tag_e      tag_q, tag_d;
    logic          ferr_q, ferr_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   fhold_q;
    logic [31:0]   lhold_q;

    logic          f_bad;
    logic          lock_mode;
    logic          starved;
    logic [1:0]    rr_req;
    logic [1:0]    rr_gnt;
    logic [1:0]    win;
    logic          f_win;

    // Loader byte-offset and high address bits are ignored by design.
    logic unused_laddr;
    assign unused_laddr = ^{l_addr[31:AW+2], l_addr[1:0]};

    assign f_bad     = fetch_addr_bad(f_addr, AW);
    assign lock_mode = (state_q == ST_LOAD) && l_lock;
    assign starved   = (starve_q >= STARVE_LIM);
    assign rr_req    = rst ? 2'b00 : {l_req, f_req};

    rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (rr_req),
        .won_i (win),
        .gnt_o (rr_gnt)
    );

    // Pick the winner: a locked loader keeps the memory unless fetch has
    // been starved long enough; otherwise plain round-robin.
    always_comb begin
        win = 2'b00;
        if (rst) begin
            win = 2'b00;
        end else if (lock_mode) begin
            if (f_req && starved) begin
                win[REQ_F] = 1'b1;
            end else if (l_req) begin
                win[REQ_L] = 1'b1;
            end else if (f_req) begin
                win[REQ_F] = 1'b1;
            end
        end else begin
            win = rr_gnt;
        end
    end

    // A bad fetch wins arbitration (for fairness) but never reaches memory.
    assign f_win     = win[REQ_F];
    assign f_gnt     = f_win && !f_bad;
    assign l_gnt     = win[REQ_L];
    assign mem_en    = f_gnt || l_gnt;
    assign mem_we    = l_gnt && l_we;
    assign mem_addr  = l_gnt ? l_addr[AW+1:2] : f_addr[AW+1:2];
    assign mem_wdata = l_gnt ? l_wdata : 32'd0;

    // Count consecutive cycles in which a pending fetch was turned away.
    always_comb begin
        starve_d = starve_q;
        if (!f_req || f_win) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Owner tracking: a locked loader keeps LOAD across idle cycles.
    always_comb begin
        state_d = state_q;
        if (f_win) begin
            state_d = ST_FETCH;
        end else if (l_gnt) begin
            state_d = ST_LOAD;
        end else if (state_q == ST_LOAD && l_lock) begin
            state_d = ST_LOAD;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Tag next cycle's read data with its owner; loader writes return nothing.
    always_comb begin
        tag_d  = RSP_NONE;
        ferr_d = 1'b0;
        if (f_win) begin
            tag_d  = RSP_FETCH;
            ferr_d = f_bad;
        end else if (l_gnt && !l_we) begin
            tag_d = RSP_LOAD;
        end
    end

    // Responses are gated by rst so an access issued just before reset is
    // dropped and every output shows its reset value during reset.
    always_comb begin
        f_rvalid = !rst && (tag_q == RSP_FETCH);
        f_err    = f_rvalid && ferr_q;
        l_rvalid = !rst && (tag_q == RSP_LOAD);
        f_rdata  = fhold_q;
        l_rdata  = lhold_q;
        if (rst) begin
            f_rdata = 32'd0;
            l_rdata = 32'd0;
        end else begin
            if (f_rvalid) begin
                f_rdata = ferr_q ? NOP_INSN : mem_rdata;
            end
            if (l_rvalid) begin
                l_rdata = mem_rdata;
            end
        end
    end

    // FSM, starve counter, response tag and read-data hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tag_q    <= RSP_NONE;
            ferr_q   <= 1'b0;
            starve_q <= '0;
            fhold_q  <= 32'd0;
            lhold_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            ferr_q   <= ferr_d;
            starve_q <= starve_d;
            fhold_q  <= f_rdata;
            lhold_q  <= l_rdata;
        end
    end

endmodule
